// File: rtl/midi_byte_tx.sv
// midi_byte_tx: buffered 8N1 MIDI serial transmitter with optional
// running-status suppression of repeated channel status bytes.
module midi_byte_tx #(
    parameter int BAUD_DIV   = 1600,
    parameter int FIFO_DEPTH = 16,
    parameter int RUN_STATUS = 1
) (
    input  logic                        reg_clk,
    input  logic                        reset_reg,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        midi_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        byte_sent,
    output logic                        byte_dropped,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] TMR_TOP = TW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      last_status, last_status_n;
    logic            rs_vld, rs_vld_n;
    logic            line_n, sent_n, drop_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, push, pop;
    logic [7:0]      head;
    logic            is_chan, is_sys, suppress;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push       = tx_valid & ~full;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign tx_ready   = ~full;
    assign fifo_level = wr_ptr - rd_ptr;
    assign tx_busy    = (state != IDLE) | ~empty;

    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (tx_valid && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge reg_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    // Channel status 0x80-0xEF participates in running status; 0xF0-0xF7 cancels it.
    assign is_chan  = head[7] && (head[7:4] != 4'hF);
    assign is_sys   = (head[7:3] == 5'b11110);
    assign suppress = (RUN_STATUS != 0) && is_chan && rs_vld && (head == last_status);

    always_comb begin
        state_n       = state;
        timer_n       = timer;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        last_status_n = last_status;
        rs_vld_n      = rs_vld;
        line_n        = 1'b1;
        sent_n        = 1'b0;
        drop_n        = 1'b0;
        pop           = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    if (suppress) begin
                        drop_n = 1'b1;
                    end else begin
                        state_n = START;
                        timer_n = TMR_TOP;
                        line_n  = 1'b0;
                        if (RUN_STATUS != 0) begin
                            if (is_chan) begin
                                last_status_n = head;
                                rs_vld_n      = 1'b1;
                            end else if (is_sys) begin
                                rs_vld_n      = 1'b0;
                            end
                        end
                    end
                end
            end
            START: begin
                line_n = 1'b0;
                if (timer == '0) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    timer_n   = TMR_TOP;
                    line_n    = shreg[0];
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            DATA: begin
                line_n = shreg[bit_idx];
                if (timer == '0) begin
                    timer_n = TMR_TOP;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        line_n  = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        line_n    = shreg[bit_idx + 3'd1];
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            STOP: begin
                line_n = 1'b1;
                if (timer == '0) begin
                    state_n = IDLE;
                    sent_n  = 1'b1;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level is registered from the next-state decode so midi_out never glitches.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= 3'd0;
            shreg        <= 8'h00;
            last_status  <= 8'h00;
            rs_vld       <= 1'b0;
            midi_out     <= 1'b1;
            byte_sent    <= 1'b0;
            byte_dropped <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            last_status  <= last_status_n;
            rs_vld       <= rs_vld_n;
            midi_out     <= line_n;
            byte_sent    <= sent_n;
            byte_dropped <= drop_n;
        end
    end

endmodule

// File: tb/tb_midi_byte_tx.sv
// Directed bench for midi_byte_tx: two instances (running status on / off)
// share clock and reset; a line receiver decodes each serial frame.
module tb_midi_byte_tx;
    localparam int BD = 4;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          reg_clk = 1'b0;
    logic          reset_reg = 1'b1;
    logic [7:0]    tx_data0 = 8'h00, tx_data1 = 8'h00;
    logic          tx_valid0 = 1'b0, tx_valid1 = 1'b0;
    logic          tx_ready0, midi_out0, tx_busy0, byte_sent0, byte_dropped0, overflow0;
    logic          tx_ready1, midi_out1, tx_busy1, byte_sent1, byte_dropped1, overflow1;
    logic [LW-1:0] fifo_level0, fifo_level1;

    int checks = 0;
    int errors = 0;
    int sent0 = 0, drop0 = 0, sent1 = 0, drop1 = 0;
    int ferr0 = 0, ferr1 = 0;
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];

    always #5 reg_clk = ~reg_clk;

    midi_byte_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .RUN_STATUS(1)) dut0 (
        .reg_clk(reg_clk), .reset_reg(reset_reg), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .midi_out(midi_out0), .tx_busy(tx_busy0), .fifo_level(fifo_level0),
        .byte_sent(byte_sent0), .byte_dropped(byte_dropped0), .overflow(overflow0));

    midi_byte_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .RUN_STATUS(0)) dut1 (
        .reg_clk(reg_clk), .reset_reg(reset_reg), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .midi_out(midi_out1), .tx_busy(tx_busy1), .fifo_level(fifo_level1),
        .byte_sent(byte_sent1), .byte_dropped(byte_dropped1), .overflow(overflow1));

    always @(negedge reg_clk) begin
        if (byte_sent0 === 1'b1)    sent0 <= sent0 + 1;
        if (byte_dropped0 === 1'b1) drop0 <= drop0 + 1;
        if (byte_sent1 === 1'b1)    sent1 <= sent1 + 1;
        if (byte_dropped1 === 1'b1) drop1 <= drop1 + 1;
    end

    function automatic logic line(input bit sel);
        return sel ? midi_out1 : midi_out0;
    endfunction

    // Called on the first low sample; samples mid-bit at BAUD_DIV=4.
    task automatic rx_frame(input bit sel, output logic [7:0] b, output bit ok);
        ok = 1'b1;
        b  = 8'h00;
        repeat (2) @(negedge reg_clk);
        if (line(sel) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge reg_clk);
            b[i] = line(sel);
        end
        repeat (4) @(negedge reg_clk);
        if (line(sel) !== 1'b1) ok = 1'b0;
    endtask

    initial begin : mon0
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge reg_clk);
            if (reset_reg === 1'b0 && midi_out0 === 1'b0) begin
                rx_frame(1'b0, b, ok);
                rxq0.push_back(b);
                if (!ok) ferr0 = ferr0 + 1;
            end
        end
    end

    initial begin : mon1
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge reg_clk);
            if (reset_reg === 1'b0 && midi_out1 === 1'b0) begin
                rx_frame(1'b1, b, ok);
                rxq1.push_back(b);
                if (!ok) ferr1 = ferr1 + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge reg_clk);
        reset_reg = 1'b1;
        repeat (2) @(negedge reg_clk);
        reset_reg = 1'b0;
        @(negedge reg_clk);
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input bit sel, input logic [7:0] d);
        int n;
        n = 0;
        while (((sel ? tx_ready1 : tx_ready0) !== 1'b1) && n < 500) begin
            @(negedge reg_clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL push_timeout: dut%0d tx_ready stayed low, byte %h", sel, d);
        end else begin
            if (sel) begin tx_data1 = d; tx_valid1 = 1'b1; end
            else     begin tx_data0 = d; tx_valid0 = 1'b1; end
            @(negedge reg_clk);
            tx_valid0 = 1'b0;
            tx_valid1 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((tx_busy0 !== 1'b0 || tx_busy1 !== 1'b0) && n < maxc) begin
            @(negedge reg_clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL idle_timeout: busy0=%b busy1=%b after %0d cycles", tx_busy0, tx_busy1, n);
        end
        repeat (3) @(negedge reg_clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge reg_clk);
        checks++;
        if ({midi_out0, tx_ready0, tx_busy0, byte_sent0, byte_dropped0, overflow0} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_outputs: got out,rdy,busy,sent,drop,ovf=%b exp 110000",
                     {midi_out0, tx_ready0, tx_busy0, byte_sent0, byte_dropped0, overflow0});
        end
        checks++;
        if (fifo_level0 !== 3'd0) begin
            errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level0);
        end
        reset_reg = 1'b0;
        @(negedge reg_clk);
        checks++;
        if (midi_out0 !== 1'b1 || tx_busy0 !== 1'b0 || midi_out1 !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_idle: got out0=%b busy0=%b out1=%b exp 1 0 1", midi_out0, tx_busy0, midi_out1);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic e;
        int b0, s0;
        d  = 8'h90;
        b0 = rxq0.size();
        s0 = sent0;
        tx_data0 = d; tx_valid0 = 1'b1;
        @(negedge reg_clk);
        tx_valid0 = 1'b0;
        checks++;
        if (fifo_level0 !== 3'd1 || midi_out0 !== 1'b1) begin
            errors++; $display("FAIL single_n1: got level=%0d out=%b exp 1 1", fifo_level0, midi_out0);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge reg_clk);
            if (k < 4)       e = 1'b0;
            else if (k < 36) e = d[(k-4)/4];
            else             e = 1'b1;
            checks++;
            if (midi_out0 !== e || byte_sent0 !== 1'b0) begin
                errors++;
                $display("FAIL single_line k=%0d: got out=%b sent=%b exp out=%b sent=0", k, midi_out0, byte_sent0, e);
            end
        end
        @(negedge reg_clk);
        checks++;
        if (byte_sent0 !== 1'b1 || midi_out0 !== 1'b1 || tx_busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got sent=%b out=%b busy=%b exp 1 1 0", byte_sent0, midi_out0, tx_busy0);
        end
        repeat (2) @(negedge reg_clk);
        checks++;
        if (rxq0.size() != b0 + 1 || sent0 != s0 + 1 || ferr0 != 0) begin
            errors++;
            $display("FAIL single_count: got frames=%0d sent=%0d ferr=%0d exp 1 1 0", rxq0.size()-b0, sent0-s0, ferr0);
        end else begin
            checks++;
            if (rxq0[b0] !== d) begin
                errors++; $display("FAIL single_rx: got %h exp %h", rxq0[b0], d);
            end
        end
    endtask

    task automatic test_running_status();
        logic [7:0] stim [6] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
        logic [7:0] exp0 [8] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'hF8, 8'hF0, 8'h90};
        logic [7:0] got;
        int b0, b1, s0, d0, s1, d1;
        do_reset();
        b0 = rxq0.size(); b1 = rxq1.size();
        s0 = sent0; d0 = drop0; s1 = sent1; d1 = drop1;
        foreach (stim[i]) push(1'b0, stim[i]);
        foreach (stim[i]) push(1'b1, stim[i]);
        wait_idle(2000);
        checks++;
        if (sent0 - s0 != 5 || drop0 - d0 != 1) begin
            errors++; $display("FAIL rs_counts: got sent=%0d dropped=%0d exp 5 1", sent0-s0, drop0-d0);
        end
        checks++;
        if (sent1 - s1 != 6 || drop1 - d1 != 0 || rxq1.size() - b1 != 6) begin
            errors++;
            $display("FAIL rs_off_counts: got sent=%0d dropped=%0d frames=%0d exp 6 0 6", sent1-s1, drop1-d1, rxq1.size()-b1);
        end
        foreach (stim[i]) begin
            got = (b1 + i < rxq1.size()) ? rxq1[b1+i] : 8'hxx;
            checks++;
            if (got !== stim[i]) begin
                errors++; $display("FAIL rs_off_rx[%0d]: got %h exp %h", i, got, stim[i]);
            end
        end
        push(1'b0, 8'hF8);
        push(1'b0, 8'h90);
        wait_idle(2000);
        checks++;
        if (drop0 - d0 != 2) begin
            errors++; $display("FAIL rs_realtime_drop: got dropped=%0d exp 2", drop0-d0);
        end
        push(1'b0, 8'hF0);
        push(1'b0, 8'h90);
        wait_idle(2000);
        checks++;
        if (drop0 - d0 != 2 || rxq0.size() - b0 != 8 || ferr0 != 0 || ferr1 != 0) begin
            errors++;
            $display("FAIL rs_sysex_counts: got dropped=%0d frames=%0d ferr=%0d/%0d exp 2 8 0 0",
                     drop0-d0, rxq0.size()-b0, ferr0, ferr1);
        end
        foreach (exp0[i]) begin
            got = (b0 + i < rxq0.size()) ? rxq0[b0+i] : 8'hxx;
            checks++;
            if (got !== exp0[i]) begin
                errors++; $display("FAIL rs_rx[%0d]: got %h exp %h", i, got, exp0[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp0 [5] = '{8'h11, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic [7:0] got;
        int b0, d0, el;
        b0 = rxq0.size(); d0 = drop0;
        push(1'b0, 8'h11);
        repeat (3) @(negedge reg_clk);
        for (int k = 0; k < 8; k++) begin
            tx_data0  = 8'hA0 + 8'(k);
            tx_valid0 = 1'b1;
            @(negedge reg_clk);
            el = (k + 1 < 4) ? k + 1 : 4;
            checks++;
            if (fifo_level0 !== LW'(el) || tx_ready0 !== (k + 1 < 4) || overflow0 !== (k >= 4)) begin
                errors++;
                $display("FAIL ovf_hold k=%0d: got level=%0d rdy=%b ovf=%b exp %0d %b %b",
                         k, fifo_level0, tx_ready0, overflow0, el, (k + 1 < 4), (k >= 4));
            end
        end
        tx_valid0 = 1'b0;
        wait_idle(2000);
        checks++;
        if (overflow0 !== 1'b1 || rxq0.size() - b0 != 5 || drop0 != d0) begin
            errors++;
            $display("FAIL ovf_final: got ovf=%b frames=%0d dropped=%0d exp 1 5 0", overflow0, rxq0.size()-b0, drop0-d0);
        end
        foreach (exp0[i]) begin
            got = (b0 + i < rxq0.size()) ? rxq0[b0+i] : 8'hxx;
            checks++;
            if (got !== exp0[i]) begin
                errors++; $display("FAIL ovf_rx[%0d]: got %h exp %h", i, got, exp0[i]);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        int b0;
        b0 = rxq0.size();
        tx_data0 = 8'h3C; tx_valid0 = 1'b1;
        @(negedge reg_clk);
        tx_data0 = 8'h55;
        @(negedge reg_clk);
        tx_valid0 = 1'b0;
        checks++;
        if (fifo_level0 !== 3'd1 || midi_out0 !== 1'b0) begin
            errors++; $display("FAIL simul_level: got level=%0d out=%b exp 1 0", fifo_level0, midi_out0);
        end
        repeat (40) @(negedge reg_clk);
        checks++;
        if (midi_out0 !== 1'b1 || byte_sent0 !== 1'b1 || fifo_level0 !== 3'd1) begin
            errors++;
            $display("FAIL b2b_idle: got out=%b sent=%b level=%0d exp 1 1 1", midi_out0, byte_sent0, fifo_level0);
        end
        @(negedge reg_clk);
        checks++;
        if (midi_out0 !== 1'b0 || fifo_level0 !== 3'd0) begin
            errors++; $display("FAIL b2b_start: got out=%b level=%0d exp 0 0", midi_out0, fifo_level0);
        end
        wait_idle(2000);
        checks++;
        if (rxq0.size() - b0 != 2 || rxq0[b0] !== 8'h3C || rxq0[b0+1] !== 8'h55) begin
            errors++;
            $display("FAIL simul_rx: got %0d frames first=%h second=%h exp 2 3c 55", rxq0.size()-b0,
                     (rxq0.size() > b0) ? rxq0[b0] : 8'hxx, (rxq0.size() > b0 + 1) ? rxq0[b0+1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0, d0;
        push(1'b0, 8'h90);
        push(1'b0, 8'h45);
        repeat (17) @(negedge reg_clk);
        #2;
        reset_reg = 1'b1;
        #1;
        checks++;
        if (midi_out0 !== 1'b1 || fifo_level0 !== 3'd0 || tx_busy0 !== 1'b0 || tx_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: got out=%b level=%0d busy=%b rdy=%b exp 1 0 0 1",
                     midi_out0, fifo_level0, tx_busy0, tx_ready0);
        end
        repeat (2) @(negedge reg_clk);
        reset_reg = 1'b0;
        repeat (50) @(negedge reg_clk);
        checks++;
        if (midi_out0 !== 1'b1 || tx_busy0 !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet: got out=%b busy=%b exp 1 0", midi_out0, tx_busy0);
        end
        b0 = rxq0.size(); d0 = drop0;
        push(1'b0, 8'h90);
        wait_idle(2000);
        checks++;
        if (rxq0.size() - b0 != 1 || drop0 != d0) begin
            errors++; $display("FAIL midreset_resend: got frames=%0d dropped=%0d exp 1 0", rxq0.size()-b0, drop0-d0);
        end else begin
            checks++;
            if (rxq0[b0] !== 8'h90) begin
                errors++; $display("FAIL midreset_rx: got %h exp 90", rxq0[b0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_running_status();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
